// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, ALU select codes,
// instruction field offsets and FSM state encoding.
//
// Instruction layout (DATA_W = immediate width):
//   {opc[2:0], rd[1:0], rs1[1:0], rs2[1:0], imm[DATA_W-1:0]}
// Field offsets below are measured from bit DATA_W (the first bit above imm).
package alu_seq_pkg;

    localparam logic [2:0] OP_MOVA = 3'b000;
    localparam logic [2:0] OP_MOVB = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LDI  = 3'b100;
    localparam logic [2:0] OP_OUT  = 3'b101;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SUB = 2'b11;

    localparam int unsigned RS2_OFS = 0;
    localparam int unsigned RS1_OFS = 2;
    localparam int unsigned RD_OFS  = 4;
    localparam int unsigned OPC_OFS = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StOut  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry register file for the ALU sequencer.
// Ports:
//   clk, rst_n            clock, async active-low clear of all entries
//   we_i/waddr_i/wdata_i  synchronous write port
//   raddr_a_i/rdata_a_o   combinational read port A
//   raddr_b_i/rdata_b_o   combinational read port B
module alu_seq_regfile #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [1:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external combinational 4-op ALU.
// Accepts one instruction per handshake, executes it in one EXEC cycle
// (writing the ALU result or an immediate into the register file), or
// presents a register on the result channel (OUT).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   instr/instr_valid/instr_ready  instruction input channel
//   alu_a/alu_b/alu_sel/alu_o      ALU operand/select outputs and result input
//   res_data/res_valid/res_ready   result output channel
//   zero                           last ALU write produced zero
//   err_illegal                    sticky illegal-opcode flag
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int unsigned DATA_W  = 4,
    localparam int unsigned INSTR_W = 9 + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [1:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_o,
    output logic [DATA_W-1:0]  res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               zero,
    output logic               err_illegal
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    // Register file interface
    logic               rf_we;
    logic [1:0]         rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [1:0]         rf_raddr_a, rf_raddr_b;
    logic [DATA_W-1:0]  rf_rdata_a, rf_rdata_b;

    // Fields of the incoming and latched instruction
    logic [1:0]         in_rs1;
    logic [2:0]         in_opc;
    logic [2:0]         q_opc;
    logic [1:0]         q_rd, q_rs1, q_rs2;
    logic [DATA_W-1:0]  q_imm;

    assign in_opc = instr[DATA_W+OPC_OFS +: 3];
    assign in_rs1 = instr[DATA_W+RS1_OFS +: 2];
    assign q_opc  = instr_q[DATA_W+OPC_OFS +: 3];
    assign q_rd   = instr_q[DATA_W+RD_OFS  +: 2];
    assign q_rs1  = instr_q[DATA_W+RS1_OFS +: 2];
    assign q_rs2  = instr_q[DATA_W+RS2_OFS +: 2];
    assign q_imm  = instr_q[DATA_W-1:0];

    alu_seq_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (rf_raddr_a),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (rf_raddr_b),
        .rdata_b_o (rf_rdata_b)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        res_data_d  = res_data_q;
        zero_d      = zero_q;
        err_d       = err_q;
        rf_we       = 1'b0;
        rf_waddr    = q_rd;
        rf_wdata    = q_imm;
        rf_raddr_a  = q_rs1;
        rf_raddr_b  = q_rs2;
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = SEL_A;
        instr_ready = 1'b0;

        case (state_q)
            StIdle: begin
                // Gated by rst_n so ready is low for the whole reset window.
                instr_ready = rst_n;
                // OUT captures its register on the acceptance edge, so port A
                // looks at the incoming instruction while idle.
                rf_raddr_a  = in_rs1;
                if (instr_valid && instr_ready) begin
                    instr_d = instr;
                    if (in_opc == OP_OUT) begin
                        res_data_d = rf_rdata_a;
                        state_d    = StOut;
                    end else begin
                        state_d    = StExec;
                    end
                end
            end
            StExec: begin
                state_d = StIdle;
                case (q_opc)
                    OP_MOVA, OP_MOVB, OP_ADD, OP_SUB: begin
                        alu_a    = rf_rdata_a;
                        alu_b    = rf_rdata_b;
                        alu_sel  = q_opc[1:0];
                        rf_we    = 1'b1;
                        rf_wdata = alu_o;
                        zero_d   = (alu_o == '0);
                    end
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = q_imm;
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
            StOut: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            res_data_q <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            res_data_q <= res_data_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
        end
    end

    // res_valid follows the state register so an async reset drops it at once.
    assign res_valid   = (state_q == StOut);
    assign res_data    = res_data_q;
    assign zero        = zero_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned INSTR_W = 9 + DATA_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [INSTR_W-1:0] instr = '0;
    logic               instr_valid = 1'b0;
    logic               instr_ready;
    logic [DATA_W-1:0]  alu_a, alu_b, alu_o, res_data;
    logic [1:0]         alu_sel;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               zero, err_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Reference model of the external 4-bit ALU
    always_comb begin
        case (alu_sel)
            2'b00:   alu_o = alu_a;
            2'b01:   alu_o = alu_b;
            2'b10:   alu_o = alu_a + alu_b;
            default: alu_o = alu_a - alu_b;
        endcase
    end

    alu_sequencer #(
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_o       (alu_o),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .zero        (zero),
        .err_illegal (err_illegal)
    );

    typedef struct {
        logic [INSTR_W-1:0] ins;
        logic [1:0]         exp_sel;   // alu_sel expected in the EXEC cycle
        logic [DATA_W-1:0]  exp_res;   // res_data expected for OUT
        logic               exp_zero;  // zero flag after the instruction
    } vec_t;

    vec_t vecs [14];

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] opc, input logic [1:0] rd,
                                              input logic [1:0] rs1, input logic [1:0] rs2,
                                              input logic [3:0] imm);
        return {opc, rd, rs1, rs2, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present an instruction at a negedge once ready is seen; returns after the
    // accepting posedge (+1) with instr_valid dropped.
    task automatic send(input logic [INSTR_W-1:0] ins);
        int waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: instr_ready got 0 expected 1");
        end
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // OUT Rs then complete the handshake immediately.
    task automatic read_reg(input logic [1:0] rs, input logic [3:0] exp, input string name);
        send(mk(3'b101, 2'd0, rs, 2'd0, 4'h0));
        @(negedge clk);
        check({name, "_valid"}, res_valid, 1);
        check(name, res_data, exp);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{mk(3'b100, 2'd0, 2'd0, 2'd0, 4'h3), 2'b00, 4'h0, 1'b0}; // LDI R0=3
        vecs[1]  = '{mk(3'b100, 2'd1, 2'd0, 2'd0, 4'h5), 2'b00, 4'h0, 1'b0}; // LDI R1=5
        vecs[2]  = '{mk(3'b011, 2'd2, 2'd0, 2'd1, 4'h0), 2'b11, 4'h0, 1'b0}; // SUB R2=E
        vecs[3]  = '{mk(3'b101, 2'd0, 2'd2, 2'd0, 4'h0), 2'b00, 4'hE, 1'b0}; // OUT R2
        vecs[4]  = '{mk(3'b100, 2'd0, 2'd0, 2'd0, 4'h9), 2'b00, 4'h0, 1'b0}; // LDI R0=9
        vecs[5]  = '{mk(3'b100, 2'd1, 2'd0, 2'd0, 4'h7), 2'b00, 4'h0, 1'b0}; // LDI R1=7
        vecs[6]  = '{mk(3'b010, 2'd3, 2'd0, 2'd1, 4'h0), 2'b10, 4'h0, 1'b1}; // ADD R3=0
        vecs[7]  = '{mk(3'b101, 2'd0, 2'd3, 2'd0, 4'h0), 2'b00, 4'h0, 1'b1}; // OUT R3
        vecs[8]  = '{mk(3'b100, 2'd1, 2'd0, 2'd0, 4'h5), 2'b00, 4'h0, 1'b1}; // LDI keeps zero
        vecs[9]  = '{mk(3'b001, 2'd2, 2'd0, 2'd1, 4'h0), 2'b01, 4'h0, 1'b0}; // MOVB R2=5
        vecs[10] = '{mk(3'b010, 2'd2, 2'd2, 2'd2, 4'h0), 2'b10, 4'h0, 1'b0}; // ADD R2=A
        vecs[11] = '{mk(3'b101, 2'd0, 2'd2, 2'd0, 4'h0), 2'b00, 4'hA, 1'b0}; // OUT R2
        vecs[12] = '{mk(3'b000, 2'd0, 2'd3, 2'd0, 4'h0), 2'b00, 4'h0, 1'b1}; // MOVA R0=R3=0
        vecs[13] = '{mk(3'b101, 2'd0, 2'd0, 2'd0, 4'h0), 2'b00, 4'h0, 1'b1}; // OUT R0

        // Reset state
        #12;
        check("rst_ready", instr_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_zero", zero, 0);
        check("rst_err", err_illegal, 0);
        check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            logic [INSTR_W-1:0] ins;
            ins = vecs[i].ins;
            send(ins);
            @(negedge clk);
            if (ins[12:10] == 3'b101) begin
                check($sformatf("v%0d_res_valid", i), res_valid, 1);
                check($sformatf("v%0d_res_data", i), res_data, vecs[i].exp_res);
                check($sformatf("v%0d_ready_out", i), instr_ready, 0);
                res_ready = 1'b1;
                @(posedge clk);
                #1;
                res_ready = 1'b0;
                @(negedge clk);
                check($sformatf("v%0d_out_done", i), {res_valid, instr_ready}, 2'b01);
            end else begin
                check($sformatf("v%0d_exec_ready", i), instr_ready, 0);
                check($sformatf("v%0d_exec_sel", i), alu_sel, vecs[i].exp_sel);
                @(negedge clk);
                check($sformatf("v%0d_idle_ready", i), instr_ready, 1);
                check($sformatf("v%0d_idle_sel", i), alu_sel, 0);
                check($sformatf("v%0d_zero", i), zero, vecs[i].exp_zero);
            end
        end

        // OUT R1 (=5) with the host stalling for 5 cycles
        send(mk(3'b101, 2'd0, 2'd1, 2'd0, 4'h0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d", c), {res_valid, res_data, instr_ready}, {1'b1, 4'h5, 1'b0});
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("stall_done", {res_valid, instr_ready}, 2'b01);

        // Illegal opcode: no write to R1, sticky error
        send(mk(3'b110, 2'd1, 2'd0, 2'd0, 4'hF));
        @(negedge clk);
        @(negedge clk);
        check("illegal_err", err_illegal, 1);
        read_reg(2'd1, 4'h5, "illegal_r1");
        send(mk(3'b100, 2'd3, 2'd0, 2'd0, 4'h6));
        read_reg(2'd3, 4'h6, "post_illegal_r3");
        check("illegal_sticky", err_illegal, 1);

        // Reset during ADD EXEC: R3=R3+R1 (6+5) must not land
        send(mk(3'b010, 2'd3, 2'd3, 2'd1, 4'h0));
        @(negedge clk);
        check("pre_rst_sel", alu_sel, 2'b10);
        rst_n = 1'b0;
        #1;
        check("rst_exec_alu", {alu_a, alu_b, alu_sel}, 0);
        check("rst_exec_flags", {instr_ready, res_valid, zero, err_illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], 4'h0, $sformatf("rst_r%0d", r));
        end

        // Reset while OUT is presenting data
        send(mk(3'b100, 2'd2, 2'd0, 2'd0, 4'h7));
        send(mk(3'b101, 2'd0, 2'd2, 2'd0, 4'h0));
        @(negedge clk);
        check("out_before_rst", {res_valid, res_data}, {1'b1, 4'h7});
        rst_n = 1'b0;
        #1;
        check("rst_out", {res_valid, res_data, instr_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        read_reg(2'd2, 4'h0, "rst_out_r2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time got 200000 expected less");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the 4-bit combinational ALU (sel: 00 pass a, 01 pass b, 10 a+b, 11 a-b).
- Accepts one instruction at a time over a valid/ready handshake and holds operands in a small register file.
- Drives the ALU's a/b/sel ports, captures its result into the register file, and keeps a zero flag.
- Returns register contents to the host on a valid/ready output channel. Sits between host/instruction source and the ALU instance.

Parameters:
- DATA_W, 4, datapath/register width; must equal the ALU operand width.
- INSTR_W, 9+DATA_W (13), instruction width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr  input  INSTR_W  {opc[12:10], rd[9:8], rs1[7:6], rs2[5:4], imm[3:0]}
- instr_valid  input  1  instr is valid
- instr_ready  output  1  sequencer can accept an instruction
- alu_a  output  DATA_W  ALU operand a
- alu_b  output  DATA_W  ALU operand b
- alu_sel  output  2  ALU operation select
- alu_o  input  DATA_W  ALU result (combinational from alu_a/alu_b/alu_sel)
- res_data  output  DATA_W  register value for OUT instruction
- res_valid  output  1  res_data valid
- res_ready  input  1  host accepts res_data
- zero  output  1  last ALU write produced 0
- err_illegal  output  1  sticky illegal-opcode flag

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - state=IDLE, all 4 registers=0, zero=0, err_illegal=0, res_valid=0, res_data=0.
  - alu_a=0, alu_b=0, alu_sel=00, instr_ready=0 while rst_n low.
- Opcodes:
  - 000 MOVA rd<=R[rs1] (sel 00)
  - 001 MOVB rd<=R[rs2] (sel 01)
  - 010 ADD rd<=R[rs1]+R[rs2] (sel 10)
  - 011 SUB rd<=R[rs1]-R[rs2] (sel 11)
  - 100 LDI rd<=imm (no ALU use)
  - 101 OUT present R[rs1]
  - 110/111 illegal.
- FSM states: IDLE, EXEC, OUT.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr.
  - Go to OUT if opc=101, else EXEC.
- EXEC (exactly one cycle, instr_ready=0):
  - alu_a=R[rs1], alu_b=R[rs2], alu_sel=opc[1:0] for opcodes 000-011.
  - At the closing edge, rf[rd]<=alu_o, zero<=(alu_o==0).
  - LDI writes imm; zero is unchanged. Illegal opcode: no write, err_illegal<=1.
  - Next state IDLE.
- Outside EXEC (and during LDI/illegal EXEC): alu_a=0, alu_b=0, alu_sel=00.
- OUT:
  - res_data<=R[rs1] captured on the acceptance edge; res_valid=1.
  - res_data is held stable until res_valid&&res_ready; then res_valid<=0 and state goes to IDLE.
  - instr_ready=0 throughout OUT.
- Latency:
  - ALU/LDI instruction accepted at edge T, register written at edge T+1, next instruction acceptable at edge T+2.
  - Throughput is one instruction per 2 cycles.
- Arithmetic: modulo 2^DATA_W. ADD carry and SUB borrow are discarded (9+7=0, 3-5=E).
- rd==rs1/rs2: operands read before the write edge, so the old value is used (R1<=R1+R1 doubles).
- Back-to-back dependency: the writing instruction completes before the next is accepted, so no hazard.
- instr_valid while instr_ready=0: ignored. The host holds instr until accepted.
- Reset mid-EXEC or mid-OUT: instruction dropped, no write, res_valid drops immediately.
- err_illegal is cleared only by reset.

Decomposition:
- Shared package/include (alu_seq_pkg):
  - opcode constants OP_MOVA..OP_OUT
  - ALU sel encodings SEL_A/SEL_B/SEL_ADD/SEL_SUB
  - instruction field bit positions
  - FSM state encoding
- One sub-module, alu_seq_regfile:
  - 4 x DATA_W registers, two combinational read ports, one synchronous write port.
  - Async active-low clear.
- The ALU itself is instantiated outside this block, not inside.

Test Plan:
- Reset then LDI R0=3, LDI R1=5, SUB R2=R0-R1, OUT R2 -> res_data=4'hE, zero=0, alu_sel=11 during SUB EXEC cycle only.
- LDI R0=9, LDI R1=7, ADD R3=R0+R1, OUT R3 -> res_data=0, zero=1 (carry dropped).
- MOVB R2<=R1 (R1=5), then ADD R2=R2+R2, OUT R2 -> res_data=4'hA; instr_ready low exactly one cycle after each acceptance.
- OUT R1 with res_ready held low 5 cycles -> res_valid=1 and res_data stable all 5 cycles, instr_ready=0; on res_ready=1, one-cycle handshake then IDLE.
- Opcode 110 -> no register changes, err_illegal=1 and stays 1 across later legal instructions.
- Assert rst_n low during EXEC of ADD and during OUT with res_valid=1 -> immediate clear of all outputs, registers read 0 after reset.
